// File: rtl/apu_reg_loader.sv
// rtl/apu_reg_loader.sv - byte-stream frame parser driving the APU register bank
// Two-byte frames (address 0x80-0x97, data) update $4000-$400F, $4015 and $4017.
module apu_reg_loader #(
  parameter int TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] reg_bank,
  output logic [7:0]   reg_4015,
  output logic [7:0]   reg_4017,
  output logic [3:0]   reg_event,
  output logic         frame_reset,
  output logic         parse_error
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  // Last DATA-state count at which a missing byte still counts as on time.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {ST_ADDR, ST_DATA} state_t;

  state_t         state_q, state_d;
  logic [4:0]     addr_q, addr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   bank_q, bank_d;
  logic [7:0]     r4015_q, r4015_d;
  logic [7:0]     r4017_q, r4017_d;
  logic [3:0]     event_q, event_d;
  logic           frame_reset_q, frame_reset_d;
  logic           parse_error_q, parse_error_d;
  logic           wr_en;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    wr_en         = 1'b0;
    parse_error_d = 1'b0;
    case (state_q)
      ST_ADDR: begin
        if (rx_valid) begin
          if (rx_data[7:5] == 3'b100 && rx_data[4:0] <= 5'h17) begin
            addr_d  = rx_data[4:0];
            cnt_d   = '0;
            state_d = ST_DATA;
          end else begin
            parse_error_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        // A byte on the final permitted edge wins over the timeout.
        if (rx_valid) begin
          wr_en   = 1'b1;
          state_d = ST_ADDR;
        end else if (cnt_q >= TO_LAST) begin
          parse_error_d = 1'b1;
          state_d       = ST_ADDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ADDR;
    endcase
  end

  always_comb begin
    bank_d        = bank_q;
    r4015_d       = r4015_q;
    r4017_d       = r4017_q;
    event_d       = 4'b0000;
    frame_reset_d = 1'b0;
    if (wr_en) begin
      if (!addr_q[4]) begin
        bank_d[{addr_q[3:0], 3'b000} +: 8] = rx_data;
        if (addr_q[1:0] == 2'b11) begin
          event_d[addr_q[3:2]] = 1'b1;
        end
      end else if (addr_q == 5'h15) begin
        r4015_d = rx_data;
      end else if (addr_q == 5'h17) begin
        r4017_d       = rx_data;
        frame_reset_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_ADDR;
      addr_q        <= '0;
      cnt_q         <= '0;
      bank_q        <= '0;
      r4015_q       <= '0;
      r4017_q       <= '0;
      event_q       <= '0;
      frame_reset_q <= 1'b0;
      parse_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      bank_q        <= bank_d;
      r4015_q       <= r4015_d;
      r4017_q       <= r4017_d;
      event_q       <= event_d;
      frame_reset_q <= frame_reset_d;
      parse_error_q <= parse_error_d;
    end
  end

  assign reg_bank    = bank_q;
  assign reg_4015    = r4015_q;
  assign reg_4017    = r4017_q;
  assign reg_event   = event_q;
  assign frame_reset = frame_reset_q;
  assign parse_error = parse_error_q;

endmodule

// File: tb/tb_apu_reg_loader.sv
// tb/tb_apu_reg_loader.sv - scoreboard bench for apu_reg_loader
// Driver updates a frame-level model per edge; monitor compares at negedges.
module tb_apu_reg_loader;

  localparam int TIMEOUT = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [127:0] reg_bank;
  logic [7:0]   reg_4015;
  logic [7:0]   reg_4017;
  logic [3:0]   reg_event;
  logic         frame_reset;
  logic         parse_error;

  apu_reg_loader #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .reg_bank   (reg_bank),
    .reg_4015   (reg_4015),
    .reg_4017   (reg_4017),
    .reg_event  (reg_event),
    .frame_reset(frame_reset),
    .parse_error(parse_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [3:0]   ev;
    logic         fr;
    logic         pe;
    logic [127:0] bank;
    logic [7:0]   r15;
    logic [7:0]   r17;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  bit           done = 1'b0;

  logic [127:0] m_bank = '0;
  logic [7:0]   m_r15 = '0;
  logic [7:0]   m_r17 = '0;
  int           m_pend = -1;
  int           m_age = 0;
  int           m_edge = 0;

  // One clock edge: drive, then advance the frame model by what that edge sampled.
  task automatic tick(input bit rst, input bit v, input logic [7:0] d, input bit chk);
    exp_t e;
    rst_n    = !rst;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    m_edge++;
    e.ev = 4'b0000;
    e.fr = 1'b0;
    e.pe = 1'b0;
    if (rst) begin
      m_bank = '0; m_r15 = '0; m_r17 = '0; m_pend = -1; m_age = 0;
    end else if (m_pend < 0) begin
      if (v) begin
        if (d >= 8'h80 && d <= 8'h97) begin
          m_pend = int'(d) - 'h80;
          m_age  = 0;
        end else begin
          e.pe = 1'b1;
        end
      end
    end else if (v) begin
      if (m_pend < 16) begin
        m_bank[m_pend*8 +: 8] = d;
        if (m_pend % 4 == 3) e.ev[m_pend/4] = 1'b1;
      end else if (m_pend == 'h15) begin
        m_r15 = d;
      end else if (m_pend == 'h17) begin
        m_r17 = d;
        e.fr  = 1'b1;
      end
      m_pend = -1;
    end else begin
      m_age++;
      if (m_age == TIMEOUT) begin
        e.pe   = 1'b1;
        m_pend = -1;
      end
    end
    if (chk || e.ev != 0 || e.fr || e.pe) begin
      e.cyc  = m_edge;
      e.bank = m_bank;
      e.r15  = m_r15;
      e.r17  = m_r17;
      sb.push_back(e);
    end
    #1;
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b, input bit chk);
    tick(1'b0, 1'b1, b, chk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  int mon_n = 0;
  always @(negedge clk) begin
    exp_t e;
    bit   hit;
    mon_n++;
    hit = 1'b0;
    while (sb.size() > 0 && sb[0].cyc <= mon_n) begin
      e   = sb.pop_front();
      hit = 1'b1;
      checks++;
      if (e.cyc != mon_n || {reg_event, frame_reset, parse_error} !== {e.ev, e.fr, e.pe}) begin
        failures++;
        $display("FAIL pulses cyc=%0d/%0d got ev=%b fr=%b pe=%b want ev=%b fr=%b pe=%b",
                 mon_n, e.cyc, reg_event, frame_reset, parse_error, e.ev, e.fr, e.pe);
      end
      checks++;
      if ({reg_bank, reg_4015, reg_4017} !== {e.bank, e.r15, e.r17}) begin
        failures++;
        $display("FAIL regs cyc=%0d got bank=%h 4015=%h 4017=%h want bank=%h 4015=%h 4017=%h",
                 mon_n, reg_bank, reg_4015, reg_4017, e.bank, e.r15, e.r17);
      end
    end
    if (!hit && (reg_event != 4'b0000 || frame_reset || parse_error)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pulse cyc=%0d got ev=%b fr=%b pe=%b want none",
               mon_n, reg_event, frame_reset, parse_error);
    end
    if (done) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL missing_pulses got pending=%0d want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int r;
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    idle(2);

    send(8'h83, 1'b0); send(8'hF9, 1'b1);
    idle(1);
    send(8'h84, 1'b0); send(8'h11, 1'b0);
    send(8'h85, 1'b0); send(8'h22, 1'b0);
    send(8'h86, 1'b0); send(8'h33, 1'b0);
    send(8'h87, 1'b0); send(8'h44, 1'b0);
    idle(1);
    send(8'h3F, 1'b0); send(8'h98, 1'b0);
    send(8'h80, 1'b0); send(8'h85, 1'b1);

    send(8'h8F, 1'b0); idle(TIMEOUT);
    send(8'h47, 1'b0); idle(2);
    send(8'h8F, 1'b0); idle(TIMEOUT - 1); send(8'hA5, 1'b0);
    idle(1);

    send(8'h97, 1'b0); send(8'hC0, 1'b0);
    send(8'h95, 1'b0); send(8'h0F, 1'b1);
    send(8'h90, 1'b0); send(8'hAA, 1'b1);

    send(8'h82, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    send(8'h55, 1'b0);
    idle(1);

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        tick(1'b1, 1'b0, 8'h00, 1'b1);
      end else if (r < 25) begin
        idle(1);
      end else if (m_pend < 0 && $urandom_range(0, 99) < 85) begin
        send(8'($urandom_range(8'h80, 8'h97)), (i % 16) == 0);
      end else begin
        send(8'($urandom), (i % 16) == 0);
      end
    end
    idle(3);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    done = 1'b1;
  end

endmodule
